// File: rtl/sc_wave_clear_ctrl_if.sv
// Signal bundle between the wave-clear controller and the game logic around it.
// The WAVECLR_DEBUG_SKIP_EN macro adds the debug skip strobe.
interface sc_wave_clear_ctrl_if #(
  parameter int KILL_WIDTH = 5
);
  logic                  SC_WAVECLR_kill_InLow;
  logic [1:0]            SC_WAVECLR_level_InBus;
  logic                  SC_WAVECLR_levelup_OutLow;
  logic                  SC_WAVECLR_pause_Out;
  logic                  SC_WAVECLR_respawn_Out;
  logic                  SC_WAVECLR_win_Out;
  logic [KILL_WIDTH-1:0] SC_WAVECLR_killcount_OutBus;
`ifdef WAVECLR_DEBUG_SKIP_EN
  logic                  SC_WAVECLR_skip_InLow;
`endif

  modport master (
    output SC_WAVECLR_kill_InLow,
    output SC_WAVECLR_level_InBus,
`ifdef WAVECLR_DEBUG_SKIP_EN
    output SC_WAVECLR_skip_InLow,
`endif
    input  SC_WAVECLR_levelup_OutLow,
    input  SC_WAVECLR_pause_Out,
    input  SC_WAVECLR_respawn_Out,
    input  SC_WAVECLR_win_Out,
    input  SC_WAVECLR_killcount_OutBus
  );

  modport slave (
    input  SC_WAVECLR_kill_InLow,
    input  SC_WAVECLR_level_InBus,
`ifdef WAVECLR_DEBUG_SKIP_EN
    input  SC_WAVECLR_skip_InLow,
`endif
    output SC_WAVECLR_levelup_OutLow,
    output SC_WAVECLR_pause_Out,
    output SC_WAVECLR_respawn_Out,
    output SC_WAVECLR_win_Out,
    output SC_WAVECLR_killcount_OutBus
  );
endinterface

// File: rtl/sc_wave_clear_ctrl.sv
// Wave-clear controller: counts kills, pauses, pulses level-up, requests respawn, or latches a win.
// Define WAVECLR_DEBUG_SKIP_EN to add the debug skip strobe that clears the wave at once.
module sc_wave_clear_ctrl #(
  parameter int ENEMY_COUNT  = 16,
  parameter int KILL_WIDTH   = 5,
  parameter int PAUSE_CYCLES = 50000000,
  parameter int PAUSE_WIDTH  = 26,
  parameter int LEVEL_MAX    = 3
) (
  input logic                SC_WAVECLR_CLOCK_50,
  input logic                SC_WAVECLR_RESET_InHigh,
  sc_wave_clear_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ST_PLAY,
    ST_PAUSE,
    ST_LEVELUP,
    ST_RESPAWN,
    ST_WIN
  } state_t;

  localparam logic [KILL_WIDTH-1:0]  KILLS_FULL = KILL_WIDTH'(ENEMY_COUNT);
  localparam logic [PAUSE_WIDTH-1:0] PAUSE_LAST = PAUSE_WIDTH'(PAUSE_CYCLES - 1);
  localparam logic [1:0]             LEVEL_TOP  = 2'(LEVEL_MAX);

  state_t                  state;
  logic [PAUSE_WIDTH-1:0]  pause_timer;
  logic [KILL_WIDTH-1:0]   kill_count;
  logic                    kill_prev;
  logic                    levelup_n;
  logic                    pause;
  logic                    respawn;
  logic                    win;

  logic                    kill_edge;
  logic                    clear_hit;
  logic [KILL_WIDTH-1:0]   count_inc;

`ifdef WAVECLR_DEBUG_SKIP_EN
  logic skip_prev;
  logic skip_edge;
`endif

  // NOTE: every signal driven here gets a default first so no latch can be inferred.
  always_comb begin
    kill_edge = kill_prev & ~bus.SC_WAVECLR_kill_InLow;
    count_inc = kill_count + 1'b1;
    clear_hit = kill_edge && (count_inc == KILLS_FULL);
`ifdef WAVECLR_DEBUG_SKIP_EN
    skip_edge = skip_prev & ~bus.SC_WAVECLR_skip_InLow;
    // A skip edge alone, or together with any kill edge, is one clear.
    clear_hit = clear_hit | skip_edge;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // sees the pre-edge values of the others.
  always_ff @(posedge SC_WAVECLR_CLOCK_50) begin
    if (SC_WAVECLR_RESET_InHigh) begin
      state       <= ST_PLAY;
      pause_timer <= '0;
      kill_count  <= '0;
      kill_prev   <= 1'b1;
      levelup_n   <= 1'b1;
      pause       <= 1'b0;
      respawn     <= 1'b0;
      win         <= 1'b0;
`ifdef WAVECLR_DEBUG_SKIP_EN
      skip_prev   <= 1'b1;
`endif
    end else begin
      kill_prev <= bus.SC_WAVECLR_kill_InLow;
`ifdef WAVECLR_DEBUG_SKIP_EN
      skip_prev <= bus.SC_WAVECLR_skip_InLow;
`endif
      unique case (state)
        ST_PLAY: begin
          if (clear_hit) begin
            kill_count <= KILLS_FULL;
            pause      <= 1'b1;
            if (bus.SC_WAVECLR_level_InBus == LEVEL_TOP) begin
              state <= ST_WIN;
              win   <= 1'b1;
            end else begin
              state       <= ST_PAUSE;
              pause_timer <= '0;
            end
          end else if (kill_edge) begin
            kill_count <= count_inc;
          end
        end
        ST_PAUSE: begin
          if (pause_timer == PAUSE_LAST) begin
            state     <= ST_LEVELUP;
            levelup_n <= 1'b0;
          end else begin
            pause_timer <= pause_timer + 1'b1;
          end
        end
        ST_LEVELUP: begin
          state      <= ST_RESPAWN;
          levelup_n  <= 1'b1;
          pause      <= 1'b0;
          respawn    <= 1'b1;
          kill_count <= '0;
        end
        ST_RESPAWN: begin
          state   <= ST_PLAY;
          respawn <= 1'b0;
        end
        ST_WIN: ;
        default: state <= ST_PLAY;
      endcase
    end
  end

  assign bus.SC_WAVECLR_levelup_OutLow   = levelup_n;
  assign bus.SC_WAVECLR_pause_Out        = pause;
  assign bus.SC_WAVECLR_respawn_Out      = respawn;
  assign bus.SC_WAVECLR_win_Out          = win;
  assign bus.SC_WAVECLR_killcount_OutBus = kill_count;

endmodule

// File: tb/tb_sc_wave_clear_ctrl.sv
// Self-checking bench for sc_wave_clear_ctrl: directed vector table, corner sequences,
// and randomized traffic against a cycles-since-clear reference model.
module tb_sc_wave_clear_ctrl;

  localparam int EC = 4;
  localparam int KW = 3;
  localparam int PC = 8;
  localparam int PW = 3;
  localparam int LM = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sc_wave_clear_ctrl_if #(.KILL_WIDTH(KW)) bus ();

  sc_wave_clear_ctrl #(
    .ENEMY_COUNT(EC), .KILL_WIDTH(KW), .PAUSE_CYCLES(PC),
    .PAUSE_WIDTH(PW), .LEVEL_MAX(LM)
  ) dut (
    .SC_WAVECLR_CLOCK_50(clk),
    .SC_WAVECLR_RESET_InHigh(rst),
    .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: kills this wave, sticky win, and cycles elapsed since a
  // non-final clear (0 while playing). Pause covers 1..PC+1, level-up PC+1, respawn PC+2.
  int m_kills, m_since;
  bit m_won, m_kprev, m_sprev;

  task automatic model_step(input bit r, input bit kill, input bit skip, input logic [1:0] lvl);
    bit ek, es;
    ek = m_kprev && !kill;
    es = m_sprev && !skip;
    if (r) begin
      m_kills = 0; m_since = 0; m_won = 0; m_kprev = 1; m_sprev = 1;
      return;
    end
    m_kprev = kill;
    m_sprev = skip;
    if (m_won) return;
    if (m_since > 0) begin
      m_since++;
      if (m_since == PC + 2) m_kills = 0;
      else if (m_since > PC + 2) m_since = 0;
      return;
    end
    if (es) m_kills = EC;
    else if (ek) m_kills++;
    if ((ek || es) && m_kills == EC) begin
      if (lvl == 2'(LM)) m_won = 1;
      else m_since = 1;
    end
  endtask

  task automatic drive_step(input bit r, input bit kill, input bit skip, input logic [1:0] lvl);
    rst = r;
    bus.SC_WAVECLR_kill_InLow  = kill;
    bus.SC_WAVECLR_level_InBus = lvl;
`ifdef WAVECLR_DEBUG_SKIP_EN
    bus.SC_WAVECLR_skip_InLow  = skip;
`endif
    model_step(r, kill, skip, lvl);
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    bit in_seq;
    in_seq = (m_since >= 1 && m_since <= PC + 1);
    check({tag, ".killcount"}, 32'(bus.SC_WAVECLR_killcount_OutBus), 32'(m_kills));
    check({tag, ".pause"},     32'(bus.SC_WAVECLR_pause_Out),        32'(m_won || in_seq));
    check({tag, ".levelup"},   32'(bus.SC_WAVECLR_levelup_OutLow),   32'(!(m_since == PC + 1)));
    check({tag, ".respawn"},   32'(bus.SC_WAVECLR_respawn_Out),      32'(m_since == PC + 2));
    check({tag, ".win"},       32'(bus.SC_WAVECLR_win_Out),          32'(m_won));
  endtask

  task automatic cyc(input string tag, input bit r, input bit kill, input logic [1:0] lvl);
    drive_step(r, kill, 1'b1, lvl);
    check_model(tag);
  endtask

  typedef struct {
    bit       rst;
    bit       kill;
    bit [1:0] lvl;
    int       kc;
    bit       pause;
    bit       levelup;
    bit       respawn;
    bit       win;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit r, input bit k, input bit [1:0] l, input int kc,
                     input bit p, input bit lu, input bit rs, input bit w);
    vec_t v;
    v = '{rst: r, kill: k, lvl: l, kc: kc, pause: p, levelup: lu, respawn: rs, win: w};
    tbl.push_back(v);
  endtask

  initial begin
    int lu_lows;
    int lu_at;
    bus.SC_WAVECLR_kill_InLow  = 1'b1;
    bus.SC_WAVECLR_level_InBus = 2'd0;
`ifdef WAVECLR_DEBUG_SKIP_EN
    bus.SC_WAVECLR_skip_InLow  = 1'b1;
`endif

    // Reset with kill toggling, then a normal clear at level 0 with ignored kills
    // during pause, level-up and respawn.
    add(1, 0, 0, 0, 0, 1, 0, 0);
    add(1, 1, 0, 0, 0, 1, 0, 0);
    add(0, 1, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 1, 0, 1, 0, 0);
    add(0, 1, 0, 1, 0, 1, 0, 0);
    add(0, 0, 0, 2, 0, 1, 0, 0);
    add(0, 1, 0, 2, 0, 1, 0, 0);
    add(0, 0, 0, 3, 0, 1, 0, 0);
    add(0, 1, 0, 3, 0, 1, 0, 0);
    add(0, 0, 0, 4, 1, 1, 0, 0);  // edge N -> pause from N+1
    add(0, 1, 0, 4, 1, 1, 0, 0);
    add(0, 0, 0, 4, 1, 1, 0, 0);  // kill during pause ignored
    add(0, 1, 0, 4, 1, 1, 0, 0);
    add(0, 0, 0, 4, 1, 1, 0, 0);
    add(0, 1, 0, 4, 1, 1, 0, 0);
    add(0, 1, 0, 4, 1, 1, 0, 0);
    add(0, 1, 0, 4, 1, 1, 0, 0);  // N+8
    add(0, 0, 0, 4, 1, 0, 0, 0);  // N+9 level-up; kill edge ignored
    add(0, 1, 0, 0, 0, 1, 1, 0);  // N+10 respawn
    add(0, 0, 0, 0, 0, 1, 0, 0);  // kill on respawn cycle ignored
    add(0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 1, 0, 0, 0, 1, 0, 0);

    foreach (tbl[i]) begin
      drive_step(tbl[i].rst, tbl[i].kill, 1'b1, tbl[i].lvl);
      check($sformatf("tbl%0d.killcount", i), 32'(bus.SC_WAVECLR_killcount_OutBus), 32'(tbl[i].kc));
      check($sformatf("tbl%0d.pause", i),     32'(bus.SC_WAVECLR_pause_Out),        32'(tbl[i].pause));
      check($sformatf("tbl%0d.levelup", i),   32'(bus.SC_WAVECLR_levelup_OutLow),   32'(tbl[i].levelup));
      check($sformatf("tbl%0d.respawn", i),   32'(bus.SC_WAVECLR_respawn_Out),      32'(tbl[i].respawn));
      check($sformatf("tbl%0d.win", i),       32'(bus.SC_WAVECLR_win_Out),          32'(tbl[i].win));
    end

    // Held kill counts once.
    for (int i = 0; i < 5; i++) cyc("held", 0, 0, 2'd0);
    check("held.count_once", 32'(bus.SC_WAVECLR_killcount_OutBus), 32'd1);
    cyc("held", 0, 1, 2'd0);

    // Final level: three more kills complete the wave, win latches, no level-up.
    for (int i = 0; i < 3; i++) begin
      cyc("win", 0, 0, 2'd3);
      cyc("win", 0, 1, 2'd3);
    end
    check("win.set", 32'(bus.SC_WAVECLR_win_Out), 32'd1);
    lu_lows = 0;
    for (int i = 0; i < 50; i++) begin
      cyc("win_hold", 0, i[0], 2'(i));
      if (bus.SC_WAVECLR_levelup_OutLow == 1'b0) lu_lows++;
    end
    check("win.no_levelup", 32'(lu_lows), 32'd0);
    check("win.killcount_full", 32'(bus.SC_WAVECLR_killcount_OutBus), 32'(EC));
    cyc("win_rst", 1, 1, 2'd0);
    check("win.cleared_by_reset", 32'(bus.SC_WAVECLR_win_Out), 32'd0);

    // Reset sampled at N+4 of a pause abandons the pending level-up.
    for (int i = 0; i < EC; i++) begin
      cyc("midpause", 0, 1, 2'd1);
      cyc("midpause", 0, 0, 2'd1);
    end
    for (int i = 0; i < 3; i++) cyc("midpause", 0, 1, 2'd1);
    cyc("midpause_rst", 1, 0, 2'd1);
    check("midpause.pause_low", 32'(bus.SC_WAVECLR_pause_Out), 32'd0);
    check("midpause.kc_zero", 32'(bus.SC_WAVECLR_killcount_OutBus), 32'd0);
    lu_lows = 0;
    for (int i = 0; i < 15; i++) begin
      cyc("midpause_after", 0, 1, 2'd1);
      if (bus.SC_WAVECLR_levelup_OutLow == 1'b0) lu_lows++;
    end
    check("midpause.no_levelup", 32'(lu_lows), 32'd0);

`ifdef WAVECLR_DEBUG_SKIP_EN
    // One skip edge with one kill on the board behaves as the final kill.
    cyc("skip", 1, 1, 2'd0);
    cyc("skip", 0, 0, 2'd0);
    cyc("skip", 0, 1, 2'd0);
    drive_step(0, 1, 0, 2'd0);
    check_model("skip_edge");
    check("skip.kc_full", 32'(bus.SC_WAVECLR_killcount_OutBus), 32'(EC));
    lu_at = -1;
    for (int i = 1; i <= PC + 3; i++) begin
      drive_step(0, 1, 1, 2'd0);
      check_model("skip_seq");
      if (bus.SC_WAVECLR_levelup_OutLow == 1'b0) lu_at = i;
    end
    check("skip.levelup_offset", 32'(lu_at), 32'(PC));
`else
    lu_at = 0;
`endif

    // Randomized traffic against the model.
    cyc("rand_rst", 1, 1, 2'd0);
    for (int i = 0; i < 3000; i++) begin
      bit r, k, s;
      logic [1:0] l;
      r = ($urandom_range(0, 199) == 0);
      k = ($urandom_range(0, 2) != 0);
      s = 1'b1;
`ifdef WAVECLR_DEBUG_SKIP_EN
      s = ($urandom_range(0, 39) != 0);
`endif
      l = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      drive_step(r, k, s, l);
      check_model("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
